// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// Optional feature macro: MEM_STAGE_BOUNDS_CHECK_EN (see mem_stage.sv).
package mem_stage_pkg;

  localparam int DEF_REGI_SIZE  = 16;
  localparam int DEF_ELEM_SIZE  = 8;
  localparam int DEF_VECT_SIZE  = 8;
  localparam int DEF_MEMO_LINES = 64;

  localparam int SCALAR_BEATS = DEF_REGI_SIZE / DEF_ELEM_SIZE;

  typedef enum logic [1:0] {
    MS_IDLE   = 2'd0,
    MS_ACCESS = 2'd1,
    MS_DONE   = 2'd2
  } memState_e;

  function automatic int addrBits(input int memo_lines);
    return $clog2(memo_lines);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-to-memory request bus and memory-to-writeback result bus.
// Used by mem_stage (MEM_STAGE_BOUNDS_CHECK_EN affects only its behaviour).
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int REGI_SIZE = DEF_REGI_SIZE,
  parameter int ELEM_SIZE = DEF_ELEM_SIZE,
  parameter int VECT_SIZE = DEF_VECT_SIZE
);

  logic                           valid_i;
  logic                           stall_o;
  logic                           enableMem_i;
  logic                           flagMemRead_i;
  logic                           flagMemWrite_i;
  logic                           vecOp_i;
  logic                           enableReg_i;
  logic [REGI_SIZE-1:0]           addr_i;
  logic [REGI_SIZE-1:0]           int_wd_i;
  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_wd_i;
  logic                           valid_o;
  logic                           enableReg_o;
  logic                           isVec_o;
  logic [REGI_SIZE-1:0]           int_res_o;
  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_res_o;
  logic                           addr_err_o;

  modport master (
    output valid_i, enableMem_i, flagMemRead_i, flagMemWrite_i, vecOp_i,
           enableReg_i, addr_i, int_wd_i, vec_wd_i,
    input  stall_o, valid_o, enableReg_o, isVec_o, int_res_o, vec_res_o,
           addr_err_o
  );

  modport slave (
    input  valid_i, enableMem_i, flagMemRead_i, flagMemWrite_i, vecOp_i,
           enableReg_i, addr_i, int_wd_i, vec_wd_i,
    output stall_o, valid_o, enableReg_o, isVec_o, int_res_o, vec_res_o,
           addr_err_o
  );

endinterface

// File: rtl/mem_stage_dmem_bank.sv
// Element-wide single-port data RAM: synchronous write, registered read, no reset.
// Independent of MEM_STAGE_BOUNDS_CHECK_EN.
module dmem_bank #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AB    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AB-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: scalar/vector loads and stores, one element per cycle.
// Define MEM_STAGE_BOUNDS_CHECK_EN to reject accesses that run past the memory end.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int REGI_SIZE  = DEF_REGI_SIZE,
  parameter int ELEM_SIZE  = DEF_ELEM_SIZE,
  parameter int VECT_SIZE  = DEF_VECT_SIZE,
  parameter int MEMO_LINES = DEF_MEMO_LINES
) (
  input  logic      clk_i,
  input  logic      rst_i,
  mem_stage_if.slave bus
);

  localparam int VW  = ELEM_SIZE * VECT_SIZE;
  localparam int AB  = addrBits(MEMO_LINES);
  localparam int SB  = REGI_SIZE / ELEM_SIZE;
  localparam int BW  = $clog2(VECT_SIZE + 1);
  localparam int AW1 = REGI_SIZE + 1;

  localparam logic [1:0] ST_IDLE   = MS_IDLE;
  localparam logic [1:0] ST_ACCESS = MS_ACCESS;
  localparam logic [1:0] ST_DONE   = MS_DONE;

  logic [1:0]           state_reg;
  logic [BW-1:0]        beat_reg;
  logic [BW-1:0]        n_beats_reg;
  logic [AB-1:0]        base_reg;
  logic                 write_reg;
  logic                 vec_reg;
  logic [VW-1:0]        wdata_reg;
  logic [VW-1:0]        asm_reg;
  logic [VW-1:0]        asm_next;

  logic                 valid_reg;
  logic                 en_reg;
  logic                 isvec_reg;
  logic                 err_reg;
  logic [REGI_SIZE-1:0] int_reg;
  logic [VW-1:0]        vec_reg_out;

  logic                 accept;
  logic                 rw_both;
  logic                 mem_op;
  logic                 oob;
  logic                 start_mem;
  logic [BW-1:0]        op_beats;

  logic                 mem_we;
  logic [AB-1:0]        mem_addr;
  logic [ELEM_SIZE-1:0] mem_rdata;
  logic                 cap_en;
  logic [BW-1:0]        cap_idx;

  assign accept   = (state_reg == ST_IDLE) && bus.valid_i;
  assign rw_both  = bus.flagMemRead_i && bus.flagMemWrite_i;
  assign mem_op   = bus.enableMem_i && (bus.flagMemRead_i ^ bus.flagMemWrite_i);
  assign op_beats = bus.vecOp_i ? BW'(VECT_SIZE) : BW'(SB);

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
  // Uses the full address width, so any upper bit set is out of range.
  logic [AW1-1:0] last_addr;
  assign last_addr = {1'b0, bus.addr_i} + AW1'(op_beats) - AW1'(1);
  assign oob       = mem_op && (last_addr >= AW1'(MEMO_LINES));
`else
  assign oob = 1'b0;
`endif

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr_i;

  assign start_mem = accept && mem_op && !oob;

  // Write enable is gated by reset so the beat in the reset cycle is abandoned.
  assign mem_we   = (state_reg == ST_ACCESS) && write_reg && rst_i;
  assign mem_addr = base_reg + AB'(beat_reg);

  dmem_bank #(
    .DEPTH (MEMO_LINES),
    .WIDTH (ELEM_SIZE),
    .AB    (AB)
  ) u_bank (
    .clk   (clk_i),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_reg[ELEM_SIZE-1:0]),
    .rdata (mem_rdata)
  );

  // Read data lags its beat by one cycle; the last element lands during MS_DONE.
  assign cap_en  = ((state_reg == ST_ACCESS) && (beat_reg != '0)) || (state_reg == ST_DONE);
  assign cap_idx = beat_reg - BW'(1);

  generate
    for (genvar gi = 0; gi < VECT_SIZE; gi++) begin : g_asm
      assign asm_next[gi*ELEM_SIZE +: ELEM_SIZE] =
        (cap_en && (cap_idx == BW'(gi))) ? mem_rdata : asm_reg[gi*ELEM_SIZE +: ELEM_SIZE];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg   <= ST_IDLE;
      beat_reg    <= '0;
      n_beats_reg <= '0;
      base_reg    <= '0;
      write_reg   <= 1'b0;
      vec_reg     <= 1'b0;
      wdata_reg   <= '0;
      asm_reg     <= '0;
      valid_reg   <= 1'b0;
      en_reg      <= 1'b0;
      isvec_reg   <= 1'b0;
      err_reg     <= 1'b0;
      int_reg     <= '0;
      vec_reg_out <= '0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_mem) begin
            state_reg   <= ST_ACCESS;
            beat_reg    <= '0;
            n_beats_reg <= op_beats;
            base_reg    <= bus.addr_i[AB-1:0];
            write_reg   <= bus.flagMemWrite_i;
            vec_reg     <= bus.vecOp_i;
            wdata_reg   <= bus.vecOp_i ? bus.vec_wd_i : VW'(bus.int_wd_i);
            asm_reg     <= '0;
          end else if (accept) begin
            valid_reg <= 1'b1;
            if (oob) begin
              err_reg     <= 1'b1;
              en_reg      <= 1'b0;
              isvec_reg   <= 1'b0;
              int_reg     <= '0;
              vec_reg_out <= '0;
            end else begin
              err_reg     <= rw_both;
              en_reg      <= bus.enableReg_i;
              isvec_reg   <= bus.vecOp_i;
              int_reg     <= bus.int_wd_i;
              vec_reg_out <= bus.vec_wd_i;
            end
          end
        end
        ST_ACCESS: begin
          asm_reg   <= asm_next;
          wdata_reg <= wdata_reg >> ELEM_SIZE;
          beat_reg  <= beat_reg + BW'(1);
          if (beat_reg == n_beats_reg - BW'(1)) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          valid_reg <= 1'b1;
          err_reg   <= 1'b0;
          isvec_reg <= vec_reg;
          if (write_reg) begin
            en_reg      <= 1'b0;
            int_reg     <= '0;
            vec_reg_out <= '0;
          end else begin
            en_reg      <= 1'b1;
            int_reg     <= vec_reg ? '0 : asm_next[REGI_SIZE-1:0];
            vec_reg_out <= vec_reg ? asm_next : '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall_o     = (state_reg != ST_IDLE);
  assign bus.valid_o     = valid_reg;
  assign bus.enableReg_o = en_reg;
  assign bus.isVec_o     = isvec_reg;
  assign bus.addr_err_o  = err_reg;
  assign bus.int_res_o   = int_reg;
  assign bus.vec_res_o   = vec_reg_out;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table plus reset and pipelining sequences.
// Covers both MEM_STAGE_BOUNDS_CHECK_EN builds.
module tb_mem_stage;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  mem_stage_if bus ();

  mem_stage dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic        en_mem;
    logic        rd;
    logic        wr;
    logic        vec;
    logic        en_reg;
    logic [15:0] addr;
    logic [15:0] int_wd;
    logic [63:0] vec_wd;
    int          exp_lat;
    logic        exp_en;
    logic [15:0] exp_int;
    logic [63:0] exp_vec;
    logic        exp_err;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.enableMem_i    = v.en_mem;
    bus.flagMemRead_i  = v.rd;
    bus.flagMemWrite_i = v.wr;
    bus.vecOp_i        = v.vec;
    bus.enableReg_i    = v.en_reg;
    bus.addr_i         = v.addr;
    bus.int_wd_i       = v.int_wd;
    bus.vec_wd_i       = v.vec_wd;
    bus.valid_i        = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk_i);
    drive(v);
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    lat = 1;
    chk($sformatf("v%0d_stall_t1", idx), 64'(bus.stall_o), 64'(v.exp_lat > 1));
    while (!bus.valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    $display("op %0d: lat %0d en %0b err %0b int %h vec %h", idx, lat,
             bus.enableReg_o, bus.addr_err_o, bus.int_res_o, bus.vec_res_o);
    chk($sformatf("v%0d_lat", idx), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("v%0d_en", idx), 64'(bus.enableReg_o), 64'(v.exp_en));
    chk($sformatf("v%0d_int", idx), 64'(bus.int_res_o), 64'(v.exp_int));
    chk($sformatf("v%0d_vec", idx), bus.vec_res_o, v.exp_vec);
    chk($sformatf("v%0d_err", idx), 64'(bus.addr_err_o), 64'(v.exp_err));
    chk($sformatf("v%0d_stall_end", idx), 64'(bus.stall_o), 64'(0));
  endtask

  function automatic vec_t mk(input logic em, input logic rd, input logic wr, input logic vc,
                              input logic er, input logic [15:0] a, input logic [15:0] iw,
                              input logic [63:0] vw, input int lat, input logic een,
                              input logic [15:0] ei, input logic [63:0] ev, input logic ee);
    vec_t r;
    r.en_mem = em; r.rd = rd; r.wr = wr; r.vec = vc; r.en_reg = er;
    r.addr = a; r.int_wd = iw; r.vec_wd = vw;
    r.exp_lat = lat; r.exp_en = een; r.exp_int = ei; r.exp_vec = ev; r.exp_err = ee;
    return r;
  endfunction

  initial begin
    vec_t v;
    logic [7:0] exp_hi [5];

    tbl[0] = mk(0, 0, 0, 0, 1, 16'd0,  16'h1234, 64'hAA, 1, 1, 16'h1234, 64'hAA, 0);
    tbl[1] = mk(1, 0, 1, 0, 0, 16'd4,  16'hBEEF, 64'h0,  4, 0, 16'h0, 64'h0, 0);
    tbl[2] = mk(1, 1, 0, 0, 1, 16'd4,  16'h0,    64'h0,  4, 1, 16'hBEEF, 64'h0, 0);
    tbl[3] = mk(1, 1, 1, 0, 1, 16'd4,  16'h5555, 64'h77, 1, 1, 16'h5555, 64'h77, 1);
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    tbl[4] = mk(1, 0, 1, 0, 0, 16'd62, 16'hCAFE, 64'h0, 4, 0, 16'h0, 64'h0, 0);
    tbl[5] = mk(1, 1, 0, 0, 1, 16'd62, 16'h0,    64'h0, 4, 1, 16'hCAFE, 64'h0, 0);
    tbl[6] = mk(1, 1, 0, 0, 1, 16'd63, 16'h9999, 64'h0, 1, 0, 16'h0, 64'h0, 1);
    tbl[7] = mk(1, 0, 1, 1, 0, 16'd60, 16'h0, 64'h1111111111111111, 1, 0, 16'h0, 64'h0, 1);
`else
    tbl[4] = mk(1, 0, 1, 1, 0, 16'd60, 16'h0, 64'h0807060504030201, 10, 0, 16'h0, 64'h0, 0);
    tbl[5] = mk(1, 1, 0, 1, 1, 16'd60, 16'h0, 64'h0, 10, 1, 16'h0, 64'h0807060504030201, 0);
    tbl[6] = mk(1, 1, 0, 0, 1, 16'h0043, 16'h0, 64'h0, 4, 1, 16'hEF08, 64'h0, 0);
    tbl[7] = mk(1, 0, 1, 1, 0, 16'd8, 16'h0, 64'h1122334455667788, 10, 0, 16'h0, 64'h0, 0);
`endif
    tbl[8] = mk(1, 0, 1, 1, 0, 16'd8, 16'h0, 64'h1122334455667788, 10, 0, 16'h0, 64'h0, 0);

    // Reset held with a valid pass-through request present.
    drive(tbl[0]);
    rst_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      chk($sformatf("rst%0d_flags", c),
          64'({bus.valid_o, bus.stall_o, bus.enableReg_o, bus.isVec_o, bus.addr_err_o}), 64'(0));
      chk($sformatf("rst%0d_int", c), 64'(bus.int_res_o), 64'(0));
      chk($sformatf("rst%0d_vec", c), bus.vec_res_o, 64'(0));
    end
    bus.valid_i = 1'b0;
    rst_i = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_vec(tbl[i], i);
    end

    chk("mem4", 64'(dut.u_bank.mem[4]), 64'hEF);
    chk("mem5", 64'(dut.u_bank.mem[5]), 64'hBE);
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    chk("mem62", 64'(dut.u_bank.mem[62]), 64'hFE);
    chk("mem63", 64'(dut.u_bank.mem[63]), 64'hCA);
`else
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("wrap_mem%0d", (60 + k) % 64), 64'(dut.u_bank.mem[(60 + k) % 64]), 64'(k + 1));
    end
`endif

    // New op accepted in the same cycle the previous result is valid.
    run_vec(tbl[2], 20);
    v = mk(0, 0, 0, 0, 1, 16'd0, 16'h0A0A, 64'h0, 1, 1, 16'h0A0A, 64'h0, 0);
    drive(v);
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    chk("overlap_valid", 64'(bus.valid_o), 64'(1));
    chk("overlap_int", 64'(bus.int_res_o), 64'h0A0A);

    // Back-to-back pass-through: one result per cycle, never stalling.
    @(negedge clk_i);
    for (int k = 1; k <= 3; k++) begin
      v = mk(0, 0, 0, 0, 1, 16'd0, 16'(k * 16'h0101), 64'h0, 1, 1, 16'h0, 64'h0, 0);
      drive(v);
      @(negedge clk_i);
      chk($sformatf("b2b%0d_valid", k), 64'(bus.valid_o), 64'(1));
      chk($sformatf("b2b%0d_int", k), 64'(bus.int_res_o), 64'(k * 16'h0101));
      chk($sformatf("b2b%0d_stall", k), 64'(bus.stall_o), 64'(0));
    end
    bus.valid_i = 1'b0;

    // Reset four cycles after accepting a vector store: only beats 0..2 land.
    @(negedge clk_i);
    v = mk(1, 0, 1, 1, 0, 16'd8, 16'h0, 64'hFFFFFFFFFFFFFFFF, 10, 0, 16'h0, 64'h0, 0);
    drive(v);
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    $display("reset mid-op: state %0d stall %0b valid %0b", dut.state_reg, bus.stall_o, bus.valid_o);
    chk("midrst_flags",
        64'({bus.valid_o, bus.stall_o, bus.enableReg_o, bus.isVec_o, bus.addr_err_o}), 64'(0));
    chk("midrst_int", 64'(bus.int_res_o), 64'(0));
    chk("midrst_vec", bus.vec_res_o, 64'(0));
    chk("midrst_state", 64'(dut.state_reg), 64'(0));
    rst_i = 1'b1;
    for (int k = 8; k <= 10; k++) begin
      chk($sformatf("midrst_mem%0d", k), 64'(dut.u_bank.mem[k]), 64'hFF);
    end
    exp_hi[0] = 8'h55; exp_hi[1] = 8'h44; exp_hi[2] = 8'h33; exp_hi[3] = 8'h22; exp_hi[4] = 8'h11;
    for (int k = 11; k <= 15; k++) begin
      chk($sformatf("midrst_mem%0d", k), 64'(dut.u_bank.mem[k]), 64'(exp_hi[k - 11]));
    end

    @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage sitting directly downstream of `superExecute`. It consumes execute results, meaning the address from `ialu_res_o`, the memory flags, and the store data. It then performs scalar (REGI_SIZE) or vector (ELEM_SIZE*VECT_SIZE) loads and stores against an element-wide single-port data memory, one element per cycle. While a multi-beat access is in flight it stalls upstream. Results go to writeback through a registered output with a valid flag.

## Interface
- REGI_SIZE, 16, scalar register width; must be a multiple of ELEM_SIZE
- ELEM_SIZE, 8, memory element width and vector lane width
- VECT_SIZE, 8, elements per vector
- MEMO_LINES, 64, data memory depth in elements; must be a power of two
- clk_i  in  1  clock; all logic is on the rising edge
- rst_i  in  1  reset, synchronous and active-low
- valid_i  in  1  execute result present this cycle
- stall_o  out  1  upstream must hold its outputs
- enableMem_i  in  1  operation accesses memory
- flagMemRead_i / flagMemWrite_i  in  1  load / store
- vecOp_i  in  1  vector access (1) or scalar access (0)
- enableReg_i  in  1  register writeback requested
- addr_i  in  REGI_SIZE  element address
- int_wd_i  in  REGI_SIZE  scalar store data, or scalar pass-through result
- vec_wd_i  in  ELEM_SIZE*VECT_SIZE  vector store data, or vector pass-through result
- valid_o  out  1  result valid, one-cycle pulse per operation
- enableReg_o  out  1  writeback enable
- isVec_o  out  1  result is vector
- int_res_o  out  REGI_SIZE  scalar result
- vec_res_o  out  ELEM_SIZE*VECT_SIZE  vector result
- addr_err_o  out  1  access rejected (see Configuration)

## Operation
- The FSM has three states: MS_IDLE, MS_ACCESS and MS_DONE. An operation is accepted only in MS_IDLE with valid_i=1.
- **Pass-through.** This applies when enableMem_i=0, or when read and write are both 1. In the second case addr_err_o=1 and no memory access occurs.
  - Outputs are registered: int_res_o=int_wd_i, vec_res_o=vec_wd_i, enableReg_o=enableReg_i.
  - The FSM stays in MS_IDLE.
- **Memory operation.** Beat count N = REGI_SIZE/ELEM_SIZE (2) for scalar, VECT_SIZE (8) for vector.
  - On accept, latch address, data, direction and vecOp, then go to MS_ACCESS with beat counter 0.
  - MS_ACCESS issues beat k to address (addr_i[ADDR_BITS-1:0] + k) mod MEMO_LINES. After beat N-1 the FSM moves to MS_DONE.
  - MS_DONE lasts one cycle, then the FSM returns to MS_IDLE.
- **Element ordering** is little-endian. Element k maps to bits [ELEM_SIZE*k +: ELEM_SIZE] of the data.
- **Store results:** enableReg_o=0 and both result buses are 0.
- **Load results:** enableReg_o=1.
  - A scalar load returns data on int_res_o, with vec_res_o=0.
  - A vector load returns data on vec_res_o, with int_res_o=0.
- **Memory reads are synchronous.** Beat k data arrives the following cycle and is assembled into a holding register. The last beat is captured in MS_DONE.
- **Address wrap.** Upper address bits beyond ADDR_BITS=$clog2(MEMO_LINES) are ignored. Beats wrap past MEMO_LINES-1 to 0.
- **Reset mid-operation:**
  - The FSM goes to MS_IDLE, the counter to 0, and all outputs to 0.
  - Beats already written remain; the remaining beats are abandoned.
  - Memory contents are never reset.

## Timing
- Reset value of every output is 0, including stall_o.
- Pass-through: accept at cycle T, valid_o=1 at T+1. stall_o stays 0.
- Memory operation: accept at T, beats at T+1..T+N, MS_DONE at T+N+1, valid_o=1 at T+N+2.
  - Scalar latency is 4; vector latency is 10.
- stall_o = (state != MS_IDLE). It is 1 from T+1 through T+N+1, and 0 from T+N+2 onward.
- A new operation may be accepted in the same cycle that valid_o is high.
- valid_i while stall_o=1 is ignored; upstream holds its outputs.
- Back-to-back pass-through operations sustain one result per cycle.

## Configuration
- MEM_STAGE_BOUNDS_CHECK_EN
  - **Defined:** an access is rejected if the full REGI_SIZE-bit addr_i + N - 1 >= MEMO_LINES. A rejected access:
    - completes as pass-through with valid_o at T+1;
    - sets addr_err_o=1, enableReg_o=0, and both result buses to 0;
    - performs no memory write and causes no stall.
  - **Undefined:** addresses wrap as described in Operation, and addr_err_o is 1 only for simultaneous read and write.

## Structure
- Package mem_stage_pkg holds:
  - typedef enum memState_e {MS_IDLE, MS_ACCESS, MS_DONE};
  - function addrBits(MEMO_LINES);
  - constant SCALAR_BEATS = REGI_SIZE/ELEM_SIZE.
- One sub-module, dmem_bank: a single-port RAM of MEMO_LINES x ELEM_SIZE with synchronous write and synchronous read, and no reset.
- The FSM, beat counter and assembly register live in mem_stage.

## Test plan
- Reset: hold rst_i=0 for 2 cycles with valid_i=1 -> all outputs 0 and stall_o=0 throughout.
- Pass-through: enableMem_i=0, enableReg_i=1, int_wd_i=0x1234 at T -> at T+1, valid_o=1, int_res_o=0x1234, enableReg_o=1, stall_o never 1.
- Scalar round trip:
  - Store 0xBEEF to address 4 at T -> stall_o over T+1..T+3, valid_o at T+4 with enableReg_o=0, mem[4]=0xEF, mem[5]=0xBE.
  - Then load address 4 -> int_res_o=0xBEEF four cycles after accept.
- Vector wrap (macro undefined):
  - Store 0x0807060504030201 at address 60 -> mem[60..63]=01..04 and mem[0..3]=05..08.
  - Vector load from 60 -> same value on vec_res_o, latency 10.
- Reset mid-operation: vector store of 0xFF per element to address 8; drop rst_i at accept+4 (beats 0..2 done) -> mem[8..10]=0xFF, mem[11..15] unchanged, outputs 0, FSM in MS_IDLE.
- Macro defined: scalar load at address 63 -> addr_err_o=1, valid_o at T+1, int_res_o=0, enableReg_o=0, no stall; memory unchanged.
